sample_cal: RTL

//   Calibrates the 4 ADC samples the ak4619 codec driver produces each frame. Applies per-channel

---
 rtl/sample_cal_pkg.sv | 24 ++
 rtl/sample_cal_if.sv | 45 ++++
 rtl/sample_cal_sat.sv | 36 +++
 rtl/sample_cal.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/sample_cal_pkg.sv
// Shared constants and types for the sample calibration block.
package sample_cal_pkg;

  localparam int unsigned W          = 16;
  localparam int unsigned GAIN_FRAC  = 14;
  localparam int unsigned N_CH       = 4;
  // Width of the 17-bit difference times the 16-bit gain.
  localparam int unsigned PW         = 2 * W + 1;

  localparam logic [W-1:0] GAIN_UNITY = 16'h4000;

  // cal_addr layout: bit 2 selects gain (1) or offset (0), bits 1:0 select the channel.
  localparam int unsigned ADDR_SEL_BIT = 2;
  localparam int unsigned ADDR_CH_MSB  = 1;
  localparam int unsigned ADDR_CH_LSB  = 0;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSub  = 2'd1,
    StMul  = 2'd2,
    StSat  = 2'd3
  } state_t;

endpackage

// File: rtl/sample_cal_if.sv
// Sample, coefficient and status bundle for sample_cal.
// SAMPLE_CAL_CLIP_EN adds the per-channel clip flags.
interface sample_cal_if;
  import sample_cal_pkg::*;

  logic                sample_strobe;
  logic signed [W-1:0] sample_in0;
  logic signed [W-1:0] sample_in1;
  logic signed [W-1:0] sample_in2;
  logic signed [W-1:0] sample_in3;
  logic                cal_we;
  logic [2:0]          cal_addr;
  logic signed [W-1:0] cal_wdata;
  logic signed [W-1:0] sample_out0;
  logic signed [W-1:0] sample_out1;
  logic signed [W-1:0] sample_out2;
  logic signed [W-1:0] sample_out3;
  logic                out_valid;
  logic                busy;
  logic                overrun;
`ifdef SAMPLE_CAL_CLIP_EN
  logic [N_CH-1:0]     clip;
`endif

  modport master (
    output sample_strobe, sample_in0, sample_in1, sample_in2, sample_in3,
    output cal_we, cal_addr, cal_wdata,
    input  sample_out0, sample_out1, sample_out2, sample_out3,
`ifdef SAMPLE_CAL_CLIP_EN
    input  clip,
`endif
    input  out_valid, busy, overrun
  );

  modport slave (
    input  sample_strobe, sample_in0, sample_in1, sample_in2, sample_in3,
    input  cal_we, cal_addr, cal_wdata,
    output sample_out0, sample_out1, sample_out2, sample_out3,
`ifdef SAMPLE_CAL_CLIP_EN
    output clip,
`endif
    output out_valid, busy, overrun
  );

endinterface

// File: rtl/sample_cal_sat.sv
// Arithmetic shift by GAIN_FRAC and clamp of a product to a W-bit signed sample.
// SAMPLE_CAL_CLIP_EN exposes the clamp flag.
module sample_cal_sat
  import sample_cal_pkg::*;
(
  input  logic signed [PW-1:0] prod,
  output logic signed [W-1:0]  sat
`ifdef SAMPLE_CAL_CLIP_EN
  ,
  output logic                 clamped
`endif
);

  logic signed [PW-1:0] shifted;
  logic [PW-W:0]        hi;
  logic                 in_range;

  // Value fits when every bit from the W-bit sign position upward agrees.
  always_comb begin
    shifted  = prod >>> GAIN_FRAC;
    hi       = shifted[PW-1:W-1];
    in_range = (&hi) | (~|hi);
    if (in_range) begin
      sat = shifted[W-1:0];
    end else if (shifted[PW-1]) begin
      sat = {1'b1, {(W-1){1'b0}}};
    end else begin
      sat = {1'b0, {(W-1){1'b1}}};
    end
  end

`ifdef SAMPLE_CAL_CLIP_EN
  assign clamped = ~in_range;
`endif

endmodule

// File: rtl/sample_cal.sv
// Per-channel offset/gain calibration of four ADC samples with one shared multiplier.
// SAMPLE_CAL_CLIP_EN adds a per-channel clip flag output.
module sample_cal
  import sample_cal_pkg::*;
(
  input logic         clk,
  input logic         rst_n,
  sample_cal_if.slave bus
);

  state_t state_q, state_d;
  logic [1:0] ch_q, ch_d;
  logic accept;
  logic last;

  logic signed [W-1:0] sample_in  [N_CH];
  logic signed [W-1:0] in_q       [N_CH];
  logic signed [W-1:0] off_pend_q [N_CH];
  logic signed [W-1:0] gain_pend_q[N_CH];
  logic signed [W-1:0] off_act_q  [N_CH];
  logic signed [W-1:0] gain_act_q [N_CH];
  logic signed [W-1:0] shadow_q   [N_CH-1];
  logic signed [W-1:0] out_q      [N_CH];
  logic signed [W:0]    diff_q;
  logic signed [PW-1:0] prod_q;
  logic signed [W-1:0]  sat_val;
  logic out_valid_q;
  logic overrun_q;

  assign sample_in[0] = bus.sample_in0;
  assign sample_in[1] = bus.sample_in1;
  assign sample_in[2] = bus.sample_in2;
  assign sample_in[3] = bus.sample_in3;

  assign accept = bus.sample_strobe && (state_q == StIdle);
  assign last   = (state_q == StSat) && (ch_q == 2'd3);

`ifdef SAMPLE_CAL_CLIP_EN
  logic                sat_clamped;
  logic [N_CH-2:0]     clip_sh_q;
  logic [N_CH-1:0]     clip_q;

  sample_cal_sat u_sat (
    .prod    (prod_q),
    .sat     (sat_val),
    .clamped (sat_clamped)
  );
`else
  sample_cal_sat u_sat (
    .prod (prod_q),
    .sat  (sat_val)
  );
`endif

  // Pending bank: written whenever cal_we is high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        off_pend_q[i]  <= '0;
        gain_pend_q[i] <= GAIN_UNITY;
      end
    end else if (bus.cal_we) begin
      if (bus.cal_addr[ADDR_SEL_BIT]) begin
        gain_pend_q[bus.cal_addr[ADDR_CH_MSB:ADDR_CH_LSB]] <= bus.cal_wdata;
      end else begin
        off_pend_q[bus.cal_addr[ADDR_CH_MSB:ADDR_CH_LSB]] <= bus.cal_wdata;
      end
    end
  end

  // Active bank: takes the pre-edge pending values when a frame is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        off_act_q[i]  <= '0;
        gain_act_q[i] <= GAIN_UNITY;
      end
    end else if (accept) begin
      for (int i = 0; i < N_CH; i++) begin
        off_act_q[i]  <= off_pend_q[i];
        gain_act_q[i] <= gain_pend_q[i];
      end
    end
  end

  // Next state: SUB/MUL/SAT per channel, back to IDLE after channel 3.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    unique case (state_q)
      StIdle: begin
        if (bus.sample_strobe) begin
          state_d = StSub;
          ch_d    = 2'd0;
        end
      end
      StSub: state_d = StMul;
      StMul: state_d = StSat;
      StSat: begin
        if (ch_q == 2'd3) begin
          state_d = StIdle;
        end else begin
          state_d = StSub;
          ch_d    = ch_q + 2'd1;
        end
      end
    endcase
  end

  // FSM state and channel counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ch_q    <= 2'd0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
    end
  end

  // Datapath: snapshot, subtract, multiply, collect into shadow, publish atomically.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        in_q[i]  <= '0;
        out_q[i] <= '0;
      end
      for (int i = 0; i < N_CH - 1; i++) begin
        shadow_q[i] <= '0;
      end
      diff_q      <= '0;
      prod_q      <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      out_valid_q <= last;
      if (bus.sample_strobe && (state_q != StIdle)) begin
        overrun_q <= 1'b1;
      end
      if (accept) begin
        for (int i = 0; i < N_CH; i++) begin
          in_q[i] <= sample_in[i];
        end
      end
      if (state_q == StSub) begin
        diff_q <= (W+1)'(in_q[ch_q]) - (W+1)'(off_act_q[ch_q]);
      end
      if (state_q == StMul) begin
        prod_q <= PW'(diff_q) * PW'(gain_act_q[ch_q]);
      end
      if (state_q == StSat) begin
        for (int i = 0; i < N_CH - 1; i++) begin
          if (ch_q == 2'(i)) begin
            shadow_q[i] <= sat_val;
          end
        end
      end
      if (last) begin
        for (int i = 0; i < N_CH - 1; i++) begin
          out_q[i] <= shadow_q[i];
        end
        out_q[N_CH-1] <= sat_val;
      end
    end
  end

`ifdef SAMPLE_CAL_CLIP_EN
  // Clip flags follow the same shadow/publish path as the samples.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clip_sh_q <= '0;
      clip_q    <= '0;
    end else begin
      if (state_q == StSat) begin
        for (int i = 0; i < N_CH - 1; i++) begin
          if (ch_q == 2'(i)) begin
            clip_sh_q[i] <= sat_clamped;
          end
        end
      end
      if (last) begin
        clip_q <= {sat_clamped, clip_sh_q};
      end
    end
  end

  assign bus.clip = clip_q;
`endif

  assign bus.sample_out0 = out_q[0];
  assign bus.sample_out1 = out_q[1];
  assign bus.sample_out2 = out_q[2];
  assign bus.sample_out3 = out_q[3];
  assign bus.out_valid   = out_valid_q;
  assign bus.busy        = (state_q != StIdle);
  assign bus.overrun     = overrun_q;

endmodule
